// File: rtl/left_line_writer.sv
// Captures one left-camera line into the line BRAM (port A), hands it to the
// line reader with a one-cycle start pulse, and holds off writes until the reader has drained.
module left_line_writer #(
    parameter int LINE_LEN = 644,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int LCNT_W   = 9
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              reader_busy,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              rea,
    output logic [LCNT_W-1:0] line_count,
    output logic              overrun,
    output logic              short_line
);

    typedef enum logic [2:0] {
        LINE_WAIT,
        WRITE,
        HANDOFF,
        DRAIN_START,
        DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              href_q, href_d;
    logic              vsync_q, vsync_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              rea_q, rea_d;
    logic [LCNT_W-1:0] line_count_q, line_count_d;
    logic              overrun_q, overrun_d;
    logic              short_line_q, short_line_d;

    logic              href_rise;
    logic              vsync_rise;
    logic              accept;
    logic              reader_owns_line;
    logic [ADDR_W-1:0] wr_addr;

    assign href_rise        = href & ~href_q;
    assign vsync_rise       = vsync & ~vsync_q;
    assign reader_owns_line = (state_q == HANDOFF) || (state_q == DRAIN_START) ||
                              (state_q == DRAIN);
    // The first pixel of a line may arrive on the href edge itself, before WRITE is entered.
    assign wr_addr          = (state_q == LINE_WAIT) ? '0 : cnt_q;

    // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        href_d       = href;
        vsync_d      = vsync;
        wea_d        = 1'b0;
        addra_d      = addra_q;
        dina_d       = dina_q;
        rea_d        = 1'b0;
        line_count_d = line_count_q;
        overrun_d    = overrun_q;
        short_line_d = 1'b0;
        accept       = 1'b0;

        if (vsync_rise) begin
            cnt_d        = '0;
            line_count_d = '0;
            overrun_d    = 1'b0;
            // A reader that may already be running must finish before the BRAM is touched again.
            if ((state_q == DRAIN_START) || (state_q == DRAIN)) begin
                state_d = DRAIN;
            end else begin
                state_d = LINE_WAIT;
            end
        end else begin
            if (href_rise && reader_owns_line) begin
                overrun_d = 1'b1;
            end

            case (state_q)
                LINE_WAIT: begin
                    if (href_rise) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                        accept  = pix_valid;
                    end
                end
                WRITE: begin
                    if (!href) begin
                        short_line_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = LINE_WAIT;
                    end else begin
                        accept = pix_valid;
                    end
                end
                HANDOFF: begin
                    if (!reader_busy) begin
                        rea_d        = 1'b1;
                        line_count_d = line_count_q + LCNT_W'(1);
                        state_d      = DRAIN_START;
                    end
                end
                DRAIN_START: begin
                    if (reader_busy) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!reader_busy) begin
                        state_d = LINE_WAIT;
                    end
                end
                default: begin
                    state_d = LINE_WAIT;
                end
            endcase

            if (accept) begin
                wea_d   = 1'b1;
                addra_d = wr_addr;
                dina_d  = pix_data;
                if (wr_addr == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = HANDOFF;
                end else begin
                    cnt_d = wr_addr + ADDR_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LINE_WAIT;
            cnt_q        <= '0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
            rea_q        <= 1'b0;
            line_count_q <= '0;
            overrun_q    <= 1'b0;
            short_line_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            href_q       <= href_d;
            vsync_q      <= vsync_d;
            wea_q        <= wea_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
            rea_q        <= rea_d;
            line_count_q <= line_count_d;
            overrun_q    <= overrun_d;
            short_line_q <= short_line_d;
        end
    end

    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign rea        = rea_q;
    assign line_count = line_count_q;
    assign overrun    = overrun_q;
    assign short_line = short_line_q;

endmodule

// File: tb/tb_left_line_writer.sv
// Scoreboard bench for left_line_writer: expected BRAM writes are queued as pixels are
// driven and popped as the DUT writes; a small reader model answers the start pulse.
module tb_left_line_writer;
    localparam int LINE_LEN = 644;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int LCNT_W   = 9;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              vsync = 1'b0;
    logic              href = 1'b0;
    logic              pix_valid = 1'b0;
    logic [DATA_W-1:0] pix_data = '0;
    logic              force_busy = 1'b0;
    logic              model_busy = 1'b0;
    logic              reader_busy;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              rea;
    logic [LCNT_W-1:0] line_count;
    logic              overrun;
    logic              short_line;

    assign reader_busy = force_busy | model_busy;

    left_line_writer #(
        .LINE_LEN(LINE_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LCNT_W(LCNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .vsync(vsync), .href(href),
        .pix_valid(pix_valid), .pix_data(pix_data), .reader_busy(reader_busy),
        .wea(wea), .addra(addra), .dina(dina), .rea(rea),
        .line_count(line_count), .overrun(overrun), .short_line(short_line)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  wr_cnt = 0, rea_cnt = 0, sl_cnt = 0;
    int  last_wr_cyc = 0, rea_cyc = 0;
    logic prev_rea = 1'b0, prev_sl = 1'b0;
    logic model_en = 1'b1;
    logic reader_active = 1'b0;
    int  busy_len = 30;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (wea) begin
                    wr_cnt++;
                    if (sb.size() == 0) begin
                        check("write_when_none_expected", 32'(wea), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", 32'(addra), 32'(e.addr));
                        check("wr_data", 32'(dina), 32'(e.data));
                    end
                    if (addra == ADDR_W'(LINE_LEN - 1)) last_wr_cyc = cyc;
                end
                if (rea) begin
                    rea_cnt++;
                    rea_cyc = cyc;
                    check("rea_with_wea", 32'(wea), 32'd0);
                    check("rea_single_cycle", 32'(prev_rea), 32'd0);
                end
                if (short_line) begin
                    sl_cnt++;
                    check("short_single_cycle", 32'(prev_sl), 32'd0);
                end
                prev_rea = rea;
                prev_sl  = short_line;
            end
        end
    end

    // Reader model: samples the start pulse, raises busy one cycle later, stays busy busy_len cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (rea === 1'b1 && model_en) begin
                reader_active = 1'b1;
                @(posedge clock);
                @(posedge clock);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(posedge clock);
                #1 model_busy = 1'b0;
                reader_active = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        tick(1);
    endtask

    task automatic send_line(input int n, input bit gapped, input bit accept,
                             input logic [DATA_W-1:0] base);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = base + DATA_W'(i);
            if (accept && i < LINE_LEN) sb.push_back('{ADDR_W'(i), base + DATA_W'(i)});
            tick(1);
            if (gapped) begin
                pix_valid = 1'b0;
                tick(1);
            end
        end
        pix_valid = 1'b0;
        href      = 1'b0;
        tick(2);
    endtask

    task automatic wait_rea(input int prev, input string tag);
        for (int i = 0; i < 300 && rea_cnt == prev; i++) tick(1);
        check(tag, 32'(rea_cnt), 32'(prev + 1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30000 && reader_active; i++) tick(1);
        check("reader_drain_timeout", 32'(reader_active), 32'd0);
        tick(3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wea"}, 32'(wea), 32'd0);
        check({tag, "_addra"}, 32'(addra), 32'd0);
        check({tag, "_dina"}, 32'(dina), 32'd0);
        check({tag, "_rea"}, 32'(rea), 32'd0);
        check({tag, "_line_count"}, 32'(line_count), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_short_line"}, 32'(short_line), 32'd0);
    endtask

    initial begin
        int wr0, r0, s0, rel;

        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(2);
        vsync_pulse();

        // Nominal line.
        wr0 = wr_cnt;
        r0  = rea_cnt;
        send_line(LINE_LEN, 1'b0, 1'b1, 8'h00);
        wait_rea(r0, "nom_rea");
        check("nom_writes", 32'(wr_cnt - wr0), 32'(LINE_LEN));
        check("nom_rea_latency", 32'(rea_cyc - last_wr_cyc), 32'd1);
        check("nom_line_count", 32'(line_count), 32'd1);
        check("nom_sb_empty", 32'(sb.size()), 32'd0);
        wait_idle();

        // Gapped pixels.
        wr0 = wr_cnt;
        r0  = rea_cnt;
        send_line(LINE_LEN, 1'b1, 1'b1, 8'h10);
        wait_rea(r0, "gap_rea");
        check("gap_writes", 32'(wr_cnt - wr0), 32'(LINE_LEN));
        check("gap_line_count", 32'(line_count), 32'd2);
        wait_idle();

        // Short line, then a full line from address 0.
        s0 = sl_cnt;
        r0 = rea_cnt;
        send_line(300, 1'b0, 1'b1, 8'h55);
        tick(5);
        check("short_pulse", 32'(sl_cnt), 32'(s0 + 1));
        check("short_no_rea", 32'(rea_cnt), 32'(r0));
        check("short_line_count", 32'(line_count), 32'd2);
        send_line(LINE_LEN, 1'b0, 1'b1, 8'hA0);
        wait_rea(r0, "after_short_rea");
        check("after_short_line_count", 32'(line_count), 32'd3);
        wait_idle();

        // Reader busy at handoff, then a line arriving while the reader drains.
        force_busy = 1'b1;
        r0 = rea_cnt;
        send_line(LINE_LEN, 1'b0, 1'b1, 8'h33);
        tick(50);
        check("busy_hold_no_rea", 32'(rea_cnt), 32'(r0));
        busy_len   = 16 * LINE_LEN;
        rel        = cyc;
        force_busy = 1'b0;
        wait_rea(r0, "busy_release_rea");
        check("busy_rea_after_release", 32'(rea_cyc - rel), 32'd1);
        check("busy_line_count", 32'(line_count), 32'd4);
        tick(20);
        wr0 = wr_cnt;
        send_line(LINE_LEN, 1'b0, 1'b0, 8'h77);
        check("overrun_no_writes", 32'(wr_cnt - wr0), 32'd0);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_line_count", 32'(line_count), 32'd4);
        wait_idle();
        check("overrun_no_rea", 32'(rea_cnt), 32'(r0 + 1));
        busy_len = 30;

        // vsync in the middle of a line.
        wr0  = wr_cnt;
        href = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'hE0 + 8'(i);
            sb.push_back('{ADDR_W'(i), 8'hE0 + 8'(i)});
            tick(1);
        end
        vsync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pix_data = 8'h44 + 8'(i);
            tick(1);
        end
        href      = 1'b0;
        pix_valid = 1'b0;
        vsync     = 1'b0;
        tick(3);
        check("vsync_mid_writes", 32'(wr_cnt - wr0), 32'd100);
        check("vsync_mid_line_count", 32'(line_count), 32'd0);
        check("vsync_mid_overrun", 32'(overrun), 32'd0);

        // vsync while the reader is draining.
        busy_len = 200;
        r0 = rea_cnt;
        send_line(LINE_LEN, 1'b0, 1'b1, 8'h01);
        wait_rea(r0, "drain_rea");
        check("drain_line_count", 32'(line_count), 32'd1);
        tick(10);
        vsync_pulse();
        check("drain_vsync_line_count", 32'(line_count), 32'd0);
        wr0 = wr_cnt;
        send_line(100, 1'b0, 1'b0, 8'h02);
        check("drain_vsync_no_writes", 32'(wr_cnt - wr0), 32'd0);
        check("drain_vsync_overrun", 32'(overrun), 32'd1);
        wait_idle();
        check("drain_vsync_no_rea", 32'(rea_cnt), 32'(r0 + 1));
        r0 = rea_cnt;
        send_line(LINE_LEN, 1'b0, 1'b1, 8'h03);
        wait_rea(r0, "post_drain_rea");
        check("post_drain_line_count", 32'(line_count), 32'd1);
        wait_idle();
        busy_len = 30;

        // Asynchronous reset in the middle of a write.
        href = 1'b1;
        for (int i = 0; i <= 400; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'h90 + 8'(i);
            if (i < 400) sb.push_back('{ADDR_W'(i), 8'h90 + 8'(i)});
            tick(1);
        end
        check("pre_reset_addra", 32'(addra), 32'd400);
        check("pre_reset_wea", 32'(wea), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        href      = 1'b0;
        pix_valid = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        r0 = rea_cnt;
        send_line(LINE_LEN, 1'b0, 1'b1, 8'hC0);
        wait_rea(r0, "post_reset_rea");
        check("post_reset_line_count", 32'(line_count), 32'd1);
        wait_idle();

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
